vote_button_ctrl: RTL and testbench



---
 rtl/vote_button_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_vote_button_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_button_ctrl.sv
// vote_button_ctrl
// Front end of the voting machine. Four raw candidate buttons are synchronised,
// debounced and turned into single-cycle vote pulses, one per press. Presses
// involving more than one button are rejected, and all buttons are ignored
// while the machine is in result-display mode.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// IDLE         | armed, waiting for a single clean button press (mode=0 only)
// DEBOUNCE     | one button latched, counting stable high cycles
// FIRE         | vote pulse for the latched candidate is on the outputs
// WAIT_RELEASE | waiting for all buttons low for DEBOUNCE_CYCLES cycles
//
// The FSM starts in WAIT_RELEASE so that a button held through reset can never
// cast a vote: it has to be released and pressed again.

module vote_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic mode,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic button4,
    output logic cand1_vote_valid,
    output logic cand2_vote_valid,
    output logic cand3_vote_valid,
    output logic cand4_vote_valid,
    output logic vote_rejected,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        WAIT_RELEASE
    } state_t;

    logic [3:0]    btn_raw;
    logic [3:0]    sync_meta;
    logic [3:0]    sync_btn;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] counter;
    logic [CW-1:0] next_counter;
    logic [3:0]    latch_q;
    logic [3:0]    next_latch;
    logic [3:0]    valid_q;
    logic [3:0]    next_valid;
    logic          rej_q;
    logic          next_rej;
    logic          busy_q;

    logic          any_btn;
    logic          single_btn;
    logic          multi_btn;
    logic          latched_high;
    logic          others_high;

    assign btn_raw = {button4, button3, button2, button1};

    // Two-flop synchroniser per button; only sync_btn is used downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_btn  <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_btn  <= sync_meta;
        end
    end

    // Button pattern classification on the synchronised inputs.
    assign any_btn      = |sync_btn;
    assign single_btn   = any_btn && ((sync_btn & (sync_btn - 4'd1)) == 4'd0);
    assign multi_btn    = any_btn && !single_btn;
    assign latched_high = |(sync_btn & latch_q);
    assign others_high  = |(sync_btn & ~latch_q);

    // State, counter and latched-button register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= WAIT_RELEASE;
            counter <= '0;
            latch_q <= '0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            latch_q <= next_latch;
        end
    end

    // Next-state, counter and output-pulse decode.
    always_comb begin
        next_state   = state;
        next_counter = counter;
        next_latch   = latch_q;
        next_valid   = '0;
        next_rej     = 1'b0;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (single_btn) begin
                        next_latch   = sync_btn;
                        next_counter = '0;
                        next_state   = DEBOUNCE;
                    end else if (multi_btn) begin
                        next_rej     = 1'b1;
                        next_counter = '0;
                        next_state   = WAIT_RELEASE;
                    end
                end
            end
            DEBOUNCE: begin
                if (!latched_high || mode) begin
                    // Too short a press, or display mode entered: drop silently.
                    next_counter = '0;
                    next_state   = IDLE;
                end else if (others_high) begin
                    next_rej     = 1'b1;
                    next_counter = '0;
                    next_state   = WAIT_RELEASE;
                end else if (counter == CNT_LAST) begin
                    next_valid   = latch_q;
                    next_counter = '0;
                    next_state   = FIRE;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end
            FIRE: begin
                next_counter = '0;
                next_state   = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Any high sample restarts the quiet period, absorbing bounces.
                if (any_btn) begin
                    next_counter = '0;
                end else if (counter == CNT_LAST) begin
                    next_counter = '0;
                    next_state   = IDLE;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end
            default: begin
                next_counter = '0;
                next_state   = WAIT_RELEASE;
            end
        endcase
    end

    // Registered outputs: pulses are set on the edge that enters FIRE or rejects.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            valid_q <= next_valid;
            rej_q   <= next_rej;
            busy_q  <= (next_state != IDLE);
        end
    end

    assign cand1_vote_valid = valid_q[0];
    assign cand2_vote_valid = valid_q[1];
    assign cand3_vote_valid = valid_q[2];
    assign cand4_vote_valid = valid_q[3];
    assign vote_rejected    = rej_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_vote_button_ctrl.sv
// Bench for vote_button_ctrl with DEBOUNCE_CYCLES=4. A press/release model
// predicts every output each cycle; directed scenarios add literal checks on
// pulse counts, latency and busy timing.

module tb_vote_button_ctrl;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mode = 1'b0;
    logic button1 = 1'b0;
    logic button2 = 1'b0;
    logic button3 = 1'b0;
    logic button4 = 1'b0;
    logic cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid;
    logic vote_rejected, busy;

    int vectors = 0;
    int miscompares = 0;
    logic check_en = 1'b0;

    always #5 clock = ~clock;

    vote_button_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clock            (clock),
        .reset            (reset),
        .mode             (mode),
        .button1          (button1),
        .button2          (button2),
        .button3          (button3),
        .button4          (button4),
        .cand1_vote_valid (cand1_vote_valid),
        .cand2_vote_valid (cand2_vote_valid),
        .cand3_vote_valid (cand3_vote_valid),
        .cand4_vote_valid (cand4_vote_valid),
        .vote_rejected    (vote_rejected),
        .busy             (busy)
    );

    logic [3:0] raw_btn;
    logic [3:0] dut_valid;
    assign raw_btn   = {button4, button3, button2, button1};
    assign dut_valid = {cand4_vote_valid, cand3_vote_valid, cand2_vote_valid, cand1_vote_valid};

    // Model: m_s2 is what the controller sees (raw delayed two edges).
    // armed   = buttons have been quiet N samples since the last vote/reject/reset
    // plen    = number of consecutive good samples of the current single press
    // firing  = the vote pulse is on the outputs this cycle
    logic [3:0] m_s1 = '0, m_s2 = '0, m_sel = '0, exp_valid = '0;
    logic exp_rej = 1'b0, exp_busy = 1'b1, m_armed = 1'b0, m_firing = 1'b0;
    int m_quiet = 0, m_plen = 0, m_nb = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_sel = '0; exp_valid = '0;
            exp_rej = 1'b0; exp_busy = 1'b1; m_armed = 1'b0; m_firing = 1'b0;
            m_quiet = 0; m_plen = 0;
        end else begin
            exp_valid = '0;
            exp_rej   = 1'b0;
            m_nb      = $countones(m_s2);
            if (m_firing) begin
                m_firing = 1'b0;
                m_armed  = 1'b0;
                m_quiet  = 0;
            end else if (!m_armed) begin
                if (m_nb == 0) begin
                    if (m_quiet == N - 1) begin
                        m_armed = 1'b1;
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                    end
                end else begin
                    m_quiet = 0;
                end
            end else if (m_plen == 0) begin
                if (!mode && m_nb == 1) begin
                    m_sel  = m_s2;
                    m_plen = 1;
                end else if (!mode && m_nb > 1) begin
                    exp_rej = 1'b1;
                    m_armed = 1'b0;
                    m_quiet = 0;
                end
            end else begin
                if (mode || (m_s2 & m_sel) == 4'd0) begin
                    m_plen = 0;
                end else if ((m_s2 & ~m_sel) != 4'd0) begin
                    exp_rej = 1'b1;
                    m_armed = 1'b0;
                    m_quiet = 0;
                    m_plen  = 0;
                end else begin
                    m_plen++;
                    if (m_plen == N + 1) begin
                        exp_valid = m_sel;
                        m_firing  = 1'b1;
                        m_plen    = 0;
                    end
                end
            end
            exp_busy = !(m_armed && m_plen == 0 && !m_firing);
            m_s2 = m_s1;
            m_s1 = raw_btn;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (check_en) begin
            vectors++;
            if (dut_valid !== exp_valid || vote_rejected !== exp_rej || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL cycle t=%0t valid=%b exp=%b rejected=%b exp=%b busy=%b exp=%b",
                         $time, dut_valid, exp_valid, vote_rejected, exp_rej, busy, exp_busy);
            end
        end
    end

    int cnt_valid[4];
    int cnt_rej = 0;

    // Pulse counters for the literal scenario checks.
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) if (dut_valid[i]) cnt_valid[i]++;
        if (vote_rejected) cnt_rej++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) cnt_valid[i] = 0;
        cnt_rej = 0;
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    int first_k;

    initial begin
        for (int i = 0; i < 4; i++) cnt_valid[i] = 0;
        #2;
        reset    = 1'b1;
        check_en = 1'b1;
        wait_cyc(3);
        check_lit("reset_busy", int'(busy), 1);
        check_lit("reset_valids", int'(dut_valid), 0);
        check_lit("reset_rejected", int'(vote_rejected), 0);
        reset = 1'b0;
        wait_cyc(10);
        check_lit("idle_after_reset_busy", int'(busy), 0);

        // 1: button2 held 20 cycles
        clear_counts();
        button2 = 1'b1;
        first_k = 0;
        for (int k = 1; k <= 20; k++) begin
            wait_cyc(1);
            if (first_k == 0 && cand2_vote_valid) first_k = k;
            if (k == 2) check_lit("t1_busy_edge2", int'(busy), 0);
            if (k == 3) check_lit("t1_busy_edge3", int'(busy), 1);
        end
        check_lit("t1_latency_edge", first_k, 7);
        button2 = 1'b0;
        wait_cyc(5);
        check_lit("t1_busy_release5", int'(busy), 1);
        wait_cyc(1);
        check_lit("t1_busy_release6", int'(busy), 0);
        check_lit("t1_cand2_pulses", cnt_valid[1], 1);
        check_lit("t1_other_pulses", cnt_valid[0] + cnt_valid[2] + cnt_valid[3], 0);

        // 2: 3-cycle glitch on button1
        clear_counts();
        button1 = 1'b1;
        wait_cyc(3);
        button1 = 1'b0;
        wait_cyc(10);
        check_lit("t2_cand1_pulses", cnt_valid[0], 0);
        check_lit("t2_busy_idle", int'(busy), 0);

        // 3: two buttons together, then button3 alone
        clear_counts();
        button1 = 1'b1;
        button3 = 1'b1;
        wait_cyc(8);
        button1 = 1'b0;
        button3 = 1'b0;
        wait_cyc(10);
        check_lit("t3_reject_pulses", cnt_rej, 1);
        check_lit("t3_no_valid", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3], 0);
        button3 = 1'b1;
        wait_cyc(10);
        button3 = 1'b0;
        wait_cyc(10);
        check_lit("t3_cand3_pulses", cnt_valid[2], 1);
        check_lit("t3_reject_total", cnt_rej, 1);

        // 4: display mode ignores button4
        clear_counts();
        mode    = 1'b1;
        button4 = 1'b1;
        wait_cyc(20);
        check_lit("t4_busy", int'(busy), 0);
        button4 = 1'b0;
        wait_cyc(5);
        mode = 1'b0;
        wait_cyc(5);
        check_lit("t4_no_valid", cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3], 0);
        check_lit("t4_no_reject", cnt_rej, 0);

        // 5: button1 held across reset
        button1 = 1'b1;
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(3);
        check_lit("t5_reset_busy", int'(busy), 1);
        reset = 1'b0;
        clear_counts();
        wait_cyc(20);
        check_lit("t5_held_no_vote", cnt_valid[0], 0);
        check_lit("t5_held_busy", int'(busy), 1);
        button1 = 1'b0;
        wait_cyc(10);
        check_lit("t5_released_idle", int'(busy), 0);
        button1 = 1'b1;
        wait_cyc(10);
        button1 = 1'b0;
        wait_cyc(10);
        check_lit("t5_cand1_pulses", cnt_valid[0], 1);

        // 6: long hold with bouncy release
        clear_counts();
        button2 = 1'b1;
        wait_cyc(100);
        repeat (3) begin
            button2 = 1'b0;
            wait_cyc(2);
            button2 = 1'b1;
            wait_cyc(2);
        end
        button2 = 1'b0;
        wait_cyc(10);
        check_lit("t6_cand2_pulses", cnt_valid[1], 1);
        check_lit("t6_busy_idle", int'(busy), 0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
